// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue / write-back stage around an external combinational 4-bit ALU.
// Optional feature: define ALU_ISSUE_FWD_EN to forward alu_r on hazards instead of stalling.
module alu_issue_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [1:0] in_rs,
    input  logic [1:0] in_rt,
    input  logic [1:0] in_rd,
    input  logic       in_imm_sel,
    input  logic [3:0] in_imm,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_r,
    input  logic       alu_z,
    input  logic       alu_o,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [3:0] wb_data,
    output logic       wb_zero,
    output logic       ovf_flag,
    input  logic       ovf_clr
);

    logic [3:0] rf_q [4];
    logic [3:0] rf_d [4];

    logic [3:0] alu_op_q, alu_op_d;
    logic [3:0] alu_a_q,  alu_a_d;
    logic [3:0] alu_b_q,  alu_b_d;
    logic [1:0] e_rd_q,   e_rd_d;
    logic       e_valid_q, e_valid_d;

    logic       wb_valid_q, wb_valid_d;
    logic [1:0] wb_rd_q,    wb_rd_d;
    logic [3:0] wb_data_q,  wb_data_d;
    logic       wb_zero_q,  wb_zero_d;
    logic       ovf_flag_q, ovf_flag_d;

    logic [3:0] rs_val, rt_val, op_a, op_b;
    logic       e_writes, hazard_a, hazard_b, accept;

    // Issue: register-file read, hazard detection and E-stage load
    always_comb begin
        rs_val   = (in_rs == 2'd0) ? 4'd0 : rf_q[in_rs];
        rt_val   = (in_rt == 2'd0) ? 4'd0 : rf_q[in_rt];
        e_writes = e_valid_q && (e_rd_q != 2'd0);
        hazard_a = e_writes && (in_rs == e_rd_q);
        hazard_b = e_writes && !in_imm_sel && (in_rt == e_rd_q);
`ifdef ALU_ISSUE_FWD_EN
        op_a     = hazard_a ? alu_r : rs_val;
        op_b     = in_imm_sel ? in_imm : (hazard_b ? alu_r : rt_val);
        in_ready = 1'b1;
`else
        // The register file only sees the write-back after this edge, so a dependent read waits a cycle.
        op_a     = rs_val;
        op_b     = in_imm_sel ? in_imm : rt_val;
        in_ready = !(hazard_a || hazard_b);
`endif
        accept   = in_valid && in_ready;

        alu_op_d  = alu_op_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        e_rd_d    = e_rd_q;
        e_valid_d = accept;
        if (accept) begin
            alu_op_d = in_op;
            alu_a_d  = op_a;
            alu_b_d  = op_b;
            e_rd_d   = in_rd;
        end
    end

    // Write-back: capture ALU outputs, update register file and sticky overflow
    always_comb begin
        for (int i = 0; i < 4; i++) rf_d[i] = rf_q[i];
        wb_valid_d = e_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_zero_d  = wb_zero_q;
        ovf_flag_d = ovf_clr ? 1'b0 : ovf_flag_q;
        if (e_valid_q) begin
            if (e_rd_q != 2'd0) rf_d[e_rd_q] = alu_r;
            wb_rd_d   = e_rd_q;
            wb_data_d = alu_r;
            wb_zero_d = alu_z;
            if (alu_o) ovf_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= 4'd0;
            alu_op_q   <= 4'd0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            e_rd_q     <= 2'd0;
            e_valid_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 2'd0;
            wb_data_q  <= 4'd0;
            wb_zero_q  <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            e_rd_q     <= e_rd_d;
            e_valid_q  <= e_valid_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_zero_q  <= wb_zero_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_zero  = wb_zero_q;
    assign ovf_flag = ovf_flag_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: architectural model with a write-back scoreboard plus directed checks.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [1:0] in_rs, in_rt, in_rd;
    logic       in_imm_sel;
    logic [3:0] in_imm;
    logic [3:0] alu_op, alu_a, alu_b;
    logic [3:0] alu_r;
    logic       alu_z, alu_o;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [3:0] wb_data;
    logic       wb_zero;
    logic       ovf_flag;
    logic       ovf_clr;

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm_sel(in_imm_sel), .in_imm(in_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_r(alu_r), .alu_z(alu_z), .alu_o(alu_o),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero),
        .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
    );

    // Reference ALU using plain signed integer arithmetic; returns {o, z, r}
    function automatic logic [5:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa, sb, s;
        logic [3:0] r;
        logic o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        o  = 1'b0;
        r  = 4'd0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin s = sa + sb; r = s[3:0]; o = (s > 7) || (s < -8); end
            4'b0110: begin s = sa - sb; r = s[3:0]; o = (s > 7) || (s < -8); end
            4'b0111: r = (sa < sb) ? 4'd1 : 4'd0;
            4'b1000: r = ~(a | b);
            4'b1101: r = ~(a & b);
            default: r = 4'd0;
        endcase
        return {o, (r == 4'd0), r};
    endfunction

    always_comb {alu_o, alu_z, alu_r} = alu_fn(alu_op, alu_a, alu_b);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Architectural model: program-order register file and expected write-back queue
    typedef struct packed { logic [1:0] rd; logic [3:0] data; logic zero; } wb_t;
    logic [3:0] m_rf [4];
    wb_t        exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        exp_q.delete();
    endtask

    task automatic model_exec(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                              input logic [1:0] rd, input logic sel, input logic [3:0] imm);
        logic [5:0] res;
        wb_t e;
        res    = alu_fn(op, m_rf[rs], sel ? imm : m_rf[rt]);
        e.rd   = rd;
        e.data = res[3:0];
        e.zero = res[4];
        exp_q.push_back(e);
        if (rd != 2'd0) m_rf[rd] = res[3:0];
    endtask

    // Scoreboard: every write-back pulse must match the next expected result
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {7'd0, wb_valid}, 8'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("sb_wb_rd",   {6'd0, wb_rd},   {6'd0, e.rd});
                chk("sb_wb_data", {4'd0, wb_data}, {4'd0, e.data});
                chk("sb_wb_zero", {7'd0, wb_zero}, {7'd0, e.zero});
            end
        end
    end

    // Offer one instruction until accepted; reports the number of stall cycles
    task automatic issue(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                         input logic [1:0] rd, input logic sel, input logic [3:0] imm,
                         output int stalls);
        logic rdy;
        bit   done;
        stalls     = 0;
        done       = 0;
        in_valid   = 1'b1;
        in_op      = op;
        in_rs      = rs;
        in_rt      = rt;
        in_rd      = rd;
        in_imm_sel = sel;
        in_imm     = imm;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) done = 1;
            else stalls++;
        end
        if (!done) chk("issue_timeout", 8'd0, 8'd1);
        else model_exec(op, rs, rt, rd, sel, imm);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int st;
    int exp_stall;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_rs = 2'd0; in_rt = 2'd0; in_rd = 2'd0;
        in_imm_sel = 1'b0; in_imm = 4'd0; ovf_clr = 1'b0;
        model_reset();
`ifdef ALU_ISSUE_FWD_EN
        exp_stall = 0;
`else
        exp_stall = 1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_alu_ops",  {alu_op, alu_a}, 8'h00);
        chk("rst_alu_b",    {4'd0, alu_b}, 8'h00);
        chk("rst_wb",       {wb_valid, wb_rd, wb_data, wb_zero}, 8'h00);
        chk("rst_ovf",      {7'd0, ovf_flag}, 8'd0);
        rst_n = 1'b1;
        idle(1);

        // Load and subtract
        issue(OP_ADD, 2'd0, 2'd0, 2'd1, 1'b1, 4'd5, st);
        idle(1);
        issue(OP_ADD, 2'd0, 2'd0, 2'd2, 1'b1, 4'd1, st);
        idle(1);
        issue(OP_SUB, 2'd1, 2'd2, 2'd3, 1'b0, 4'd0, st);
        idle(1);
        chk("ls_wb_valid", {7'd0, wb_valid}, 8'd1);
        chk("ls_wb", {wb_rd, wb_data, wb_zero}, {2'd3, 4'b0100, 1'b0});

        // Back-to-back dependency
        issue(OP_ADD, 2'd0, 2'd0, 2'd1, 1'b1, 4'd7, st);
        issue(OP_ADD, 2'd1, 2'd0, 2'd2, 1'b1, 4'd1, st);
        chk("dep_stalls", st[7:0], exp_stall[7:0]);
        chk("dep_alu_a", {4'd0, alu_a}, 8'h07);
        idle(1);
        chk("dep_wb", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd2, 4'b1000});
        chk("dep_ovf", {7'd0, ovf_flag}, 8'd1);

        // r0 write discarded
        issue(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 4'd3, st);
        idle(1);
        chk("r0_wb", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd0, 4'b0011});
        issue(OP_AND, 2'd0, 2'd0, 2'd1, 1'b1, 4'hF, st);
        chk("r0_alu_a", {4'd0, alu_a}, 8'h00);
        idle(1);
        chk("r0_and_wb", {3'd0, wb_data, wb_zero}, {3'd0, 4'b0000, 1'b1});

        // Sticky overflow: clear, then set and clear in the same cycle
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", {7'd0, ovf_flag}, 8'd0);
        issue(OP_ADD, 2'd0, 2'd0, 2'd1, 1'b1, 4'hE, st);
        issue(OP_OR,  2'd0, 2'd0, 2'd2, 1'b1, 4'h7, st);
        issue(OP_SUB, 2'd1, 2'd2, 2'd3, 1'b0, 4'd0, st);
        chk("sub_ovf_before", {7'd0, ovf_flag}, 8'd0);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", {7'd0, ovf_flag}, 8'd1);
        chk("sub_wb_data", {4'd0, wb_data}, 8'h07);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_clr_alone", {7'd0, ovf_flag}, 8'd0);

        // SLT in both operand orders
        issue(OP_ADD, 2'd0, 2'd0, 2'd1, 1'b1, 4'd1, st);
        issue(OP_ADD, 2'd0, 2'd0, 2'd2, 1'b1, 4'd3, st);
        issue(OP_SLT, 2'd1, 2'd2, 2'd3, 1'b0, 4'd0, st);
        idle(1);
        chk("slt_lt", {3'd0, wb_data, wb_zero}, {3'd0, 4'b0001, 1'b0});
        issue(OP_SLT, 2'd2, 2'd1, 2'd3, 1'b0, 4'd0, st);
        idle(1);
        chk("slt_ge", {3'd0, wb_data, wb_zero}, {3'd0, 4'b0000, 1'b1});

        // Asynchronous reset with an instruction in E: no write-back, register file cleared
        issue(OP_ADD, 2'd0, 2'd0, 2'd1, 1'b1, 4'd9, st);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_wb_valid", {7'd0, wb_valid}, 8'd0);
        @(posedge clk); #1;
        chk("arst_hold_wb", {7'd0, wb_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_after_wb", {7'd0, wb_valid}, 8'd0);
        chk("arst_in_ready", {7'd0, in_ready}, 8'd1);
        issue(OP_ADD, 2'd3, 2'd0, 2'd2, 1'b1, 4'd0, st);
        idle(1);
        chk("arst_rf_clear", {3'd0, wb_data, wb_zero}, {3'd0, 4'b0000, 1'b1});

        idle(2);
        chk("wb_queue_drained", exp_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
